// File: rtl/keypad_pkg.sv
// Shared types and helpers for the matrix-keypad scanner.
package keypad_pkg;

  typedef enum logic [1:0] {SETTLE, SAMPLE, EVAL} scan_state_t;
  typedef enum logic [1:0] {NONE, SINGLE, MULTI} frame_class_t;

  function automatic int key_code(input int row_idx, input int col_idx, input int ncols);
    return row_idx * ncols + col_idx;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous level inputs.
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// Matrix-keypad scanner: column strobe, frame-level debounce, press/release
// events on a valid/ready port with a sticky overflow flag.
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter int  NROWS          = 4,
  parameter int  NCOLS          = 4,
  parameter int  SETTLE_CYCLES  = 16,
  parameter int  DEBOUNCE_SCANS = 3,
  localparam int KEY_W          = $clog2(NROWS * NCOLS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NROWS-1:0] row,
  output logic [NCOLS-1:0] col,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [KEY_W-1:0] evt_code,
  output logic             evt_release,
  output logic             key_held,
  output logic             multi_key,
  output logic             evt_ovf,
  input  logic             ovf_clr
);

  localparam int         NKEYS = NROWS * NCOLS;
  localparam int         CW    = $clog2(NCOLS);
  localparam int         SW    = $clog2(SETTLE_CYCLES);
  localparam logic [3:0] DB    = 4'(DEBOUNCE_SCANS);

  logic [NROWS-1:0] sync_row;

  sync_2ff #(.W(NROWS)) u_row_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (row),
    .q     (sync_row)
  );

  scan_state_t  state_q, state_d;
  logic [CW-1:0] col_idx_q, col_idx_d;
  logic [SW-1:0] settle_q, settle_d;
  logic [NKEYS-1:0] acc_q, acc_d;
  frame_class_t fclass;
  logic [KEY_W-1:0] fcode;
  int ones;
  logic [KEY_W-1:0] cand_q, cand_d, held_code_q, held_code_d, gen_code;
  logic [3:0] cand_cnt_q, cand_cnt_d, none_q, none_d, cnt_next;
  logic held_q, held_d, multi_q, multi_d, gen, gen_rel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= SETTLE;
      col_idx_q   <= '0;
      settle_q    <= '0;
      acc_q       <= '0;
      cand_q      <= '0;
      cand_cnt_q  <= '0;
      held_code_q <= '0;
      none_q      <= '0;
      held_q      <= 1'b0;
      multi_q     <= 1'b0;
      col         <= '0;
    end else begin
      state_q     <= state_d;
      col_idx_q   <= col_idx_d;
      settle_q    <= settle_d;
      acc_q       <= acc_d;
      cand_q      <= cand_d;
      cand_cnt_q  <= cand_cnt_d;
      held_code_q <= held_code_d;
      none_q      <= none_d;
      held_q      <= held_d;
      multi_q     <= multi_d;
      // Registered from next state so col reads 0 out of reset.
      col         <= (state_d == EVAL) ? '0 : (NCOLS'(1) << col_idx_d);
    end
  end

  always_comb begin
    state_d     = state_q;
    col_idx_d   = col_idx_q;
    settle_d    = settle_q;
    acc_d       = acc_q;
    ones        = 0;
    fcode       = '0;
    cand_d      = cand_q;
    cand_cnt_d  = cand_cnt_q;
    held_code_d = held_code_q;
    none_d      = none_q;
    held_d      = held_q;
    multi_d     = multi_q;
    gen         = 1'b0;
    gen_code    = '0;
    gen_rel     = 1'b0;

    // Downward walk leaves fcode at the lowest set index.
    for (int i = NKEYS - 1; i >= 0; i--) begin
      if (acc_q[i]) begin
        ones  = ones + 1;
        fcode = KEY_W'(i);
      end
    end
    fclass   = (ones == 0) ? NONE : ((ones == 1) ? SINGLE : MULTI);
    cnt_next = (fcode != cand_q) ? 4'd1 : ((cand_cnt_q == DB) ? DB : cand_cnt_q + 4'd1);

    case (state_q)
      SETTLE: begin
        if (settle_q == SW'(SETTLE_CYCLES - 1)) begin
          settle_d = '0;
          state_d  = SAMPLE;
        end else begin
          settle_d = settle_q + SW'(1);
        end
      end
      SAMPLE: begin
        for (int r = 0; r < NROWS; r++) begin
          acc_d[KEY_W'(key_code(r, int'(col_idx_q), NCOLS))] =
            acc_q[KEY_W'(key_code(r, int'(col_idx_q), NCOLS))] | sync_row[r];
        end
        if (col_idx_q == CW'(NCOLS - 1)) begin
          state_d = EVAL;
        end else begin
          col_idx_d = col_idx_q + CW'(1);
          state_d   = SETTLE;
        end
      end
      default: begin
        acc_d     = '0;
        col_idx_d = '0;
        state_d   = SETTLE;
        multi_d   = (fclass == MULTI);
        if (fclass == MULTI) begin
          cand_cnt_d = '0;
          none_d     = '0;
        end else if (!held_q) begin
          if (fclass == SINGLE) begin
            cand_d = fcode;
            if (cnt_next == DB) begin
              held_d      = 1'b1;
              held_code_d = fcode;
              cand_cnt_d  = '0;
              none_d      = '0;
              gen         = 1'b1;
              gen_code    = fcode;
            end else begin
              cand_cnt_d = cnt_next;
            end
          end else begin
            cand_cnt_d = '0;
          end
        end else if (fclass == NONE) begin
          if (none_q + 4'd1 == DB) begin
            held_d   = 1'b0;
            none_d   = '0;
            gen      = 1'b1;
            gen_code = held_code_q;
            gen_rel  = 1'b1;
          end else begin
            none_d = none_q + 4'd1;
          end
        end else if (fcode == held_code_q) begin
          none_d = '0;
        end
      end
    endcase
  end

  // Handshake: an event transfers on any cycle with evt_valid & evt_ready;
  // evt_code/evt_release hold steady while evt_valid is high and unaccepted.
  logic accept;
  assign accept = evt_valid & evt_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_valid   <= 1'b0;
      evt_code    <= '0;
      evt_release <= 1'b0;
      evt_ovf     <= 1'b0;
    end else begin
      if (gen && (!evt_valid || accept)) begin
        evt_valid   <= 1'b1;
        evt_code    <= gen_code;
        evt_release <= gen_rel;
      end else if (accept) begin
        evt_valid <= 1'b0;
      end
      if (gen && evt_valid && !accept) evt_ovf <= 1'b1;
      else if (ovf_clr)                evt_ovf <= 1'b0;
    end
  end

  assign key_held  = held_q;
  assign multi_key = multi_q;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Scoreboard bench for keypad_scan_ctrl with a behavioural 4x4 keypad matrix.
module tb_keypad_scan_ctrl;

  localparam int KEY_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [3:0]       row;
  logic [3:0]       col;
  logic             evt_valid;
  logic             evt_ready;
  logic [KEY_W-1:0] evt_code;
  logic             evt_release;
  logic             key_held;
  logic             multi_key;
  logic             evt_ovf;
  logic             ovf_clr;

  logic [15:0]      keys;
  logic [KEY_W:0]   exp_q[$];
  int               checks = 0;
  int               errors = 0;

  keypad_scan_ctrl #(
    .NROWS(4), .NCOLS(4), .SETTLE_CYCLES(4), .DEBOUNCE_SCANS(3)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .row         (row),
    .col         (col),
    .evt_valid   (evt_valid),
    .evt_ready   (evt_ready),
    .evt_code    (evt_code),
    .evt_release (evt_release),
    .key_held    (key_held),
    .multi_key   (multi_key),
    .evt_ovf     (evt_ovf),
    .ovf_clr     (ovf_clr)
  );

  // clock / reset
  always #5 clk = ~clk;

  // Key k = r*4+c closes row r onto column c.
  always_comb begin
    for (int r = 0; r < 4; r++) row[r] = |(keys[r*4 +: 4] & col);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // scoreboard monitor
  logic [KEY_W:0] prev_evt;
  logic           prev_stall = 1'b0;

  always @(negedge clk) begin
    if (rst_n && evt_valid && prev_stall)
      check("evt_stable", {27'd0, evt_release, evt_code}, {27'd0, prev_evt});
    if (rst_n && evt_valid && evt_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event: got rel=%0d code=%0d expected none", evt_release, evt_code);
      end else begin
        check("event", {27'd0, evt_release, evt_code}, {27'd0, exp_q.pop_front()});
      end
    end
    prev_stall = rst_n && evt_valid && !evt_ready;
    prev_evt   = {evt_release, evt_code};
  end

  // driver tasks
  task automatic wait_eval();
    int n;
    n = 0;
    @(negedge clk);
    while (col !== 4'b0000 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL eval_timeout: got col=%b expected 0000 within 100 cycles", col);
    end
  endtask

  task automatic run_frames(input logic [15:0] k, input int n);
    keys = k;
    repeat (n) wait_eval();
  endtask

  task automatic check_drained(input string name);
    repeat (2) @(negedge clk);
    check(name, exp_q.size(), 0);
    wait_eval();
  endtask

  initial begin
    rst_n     = 1'b0;
    keys      = '0;
    evt_ready = 1'b1;
    ovf_clr   = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_col", col, 0);
    check("rst_valid", evt_valid, 0);
    check("rst_code", evt_code, 0);
    check("rst_release", evt_release, 0);
    check("rst_held", key_held, 0);
    check("rst_multi", multi_key, 0);
    check("rst_ovf", evt_ovf, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    wait_eval();

    // idle scan pattern: each column 5 cycles, then one EVAL cycle of 0
    for (int c = 0; c < 4; c++) begin
      repeat (5) begin
        @(negedge clk);
        check("scan_col", col, 32'(4'b0001 << c));
      end
    end
    @(negedge clk);
    check("scan_eval_col", col, 0);

    // press key 10 (row 2, col 2)
    run_frames(16'h0400, 2);
    check("press_not_yet", key_held, 0);
    exp_q.push_back({1'b0, 4'd10});
    run_frames(16'h0400, 1);
    check_drained("press_latency");
    check("press_held", key_held, 1);
    run_frames(16'h0400, 1);

    // release key 10
    exp_q.push_back({1'b1, 4'd10});
    run_frames(16'h0000, 3);
    check_drained("release_latency");
    check("release_held", key_held, 0);

    // bounce on key 5
    run_frames(16'h0020, 2);
    run_frames(16'h0000, 1);
    run_frames(16'h0020, 2);
    check("bounce_not_yet", key_held, 0);
    exp_q.push_back({1'b0, 4'd5});
    run_frames(16'h0020, 1);
    check_drained("bounce_press");
    check("bounce_held", key_held, 1);
    exp_q.push_back({1'b1, 4'd5});
    run_frames(16'h0000, 3);
    check_drained("bounce_release");

    // keys 0 and 15 together
    run_frames(16'h8001, 5);
    check("multi_flag", multi_key, 1);
    check("multi_held", key_held, 0);
    run_frames(16'h0000, 1);
    @(negedge clk);
    check("multi_clear", multi_key, 0);
    wait_eval();

    // backpressure: press held on the port, release dropped
    evt_ready = 1'b0;
    exp_q.push_back({1'b0, 4'd10});
    run_frames(16'h0400, 3);
    run_frames(16'h0000, 3);
    repeat (2) @(negedge clk);
    check("bp_ovf", evt_ovf, 1);
    check("bp_valid", evt_valid, 1);
    check("bp_code", evt_code, 10);
    check("bp_release", evt_release, 0);
    check("bp_held", key_held, 0);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    check("ovf_clr", evt_ovf, 0);
    @(posedge clk);
    #1 evt_ready = 1'b1;
    check_drained("bp_drain");

    // reset mid-frame with a pending press and a held key
    evt_ready = 1'b0;
    run_frames(16'h0080, 3);
    repeat (2) @(negedge clk);
    check("pend_valid", evt_valid, 1);
    check("pend_code", evt_code, 7);
    check("pend_held", key_held, 1);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_valid", evt_valid, 0);
    check("mid_rst_held", key_held, 0);
    check("mid_rst_col", col, 0);
    keys      = '0;
    evt_ready = 1'b1;
    rst_n     = 1'b1;
    repeat (3) @(negedge clk);
    wait_eval();
    run_frames(16'h0000, 4);
    check("post_rst_held", key_held, 0);
    check("post_rst_ovf", evt_ovf, 0);
    check_drained("post_rst_quiet");

    check("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
